mem_fill_engine: RTL and testbench

Parametrised hardware memory fill/verify engine. It replaces software fill loops such as a 0xFEFE store loop with a single-command block that writes or checks a run of words in data memory. It sits beside the data memory on the processor's data-port side and drives one word-wide port at one word per cycle. Supported patterns are constant and incrementing, with a verify mode that counts mismatches.

---
 rtl/mem_fill_pkg.sv | 28 ++
 rtl/mem_fill_engine_if.sv | 45 ++++
 rtl/mem_fill_pattern.sv | 23 ++
 rtl/mem_fill_engine.sv | 133 +++++++++++++
 tb/tb_mem_fill_engine.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_fill_pkg.sv
// ============================================================================
//  Module  : mem_fill_pkg
//  Brief   : Shared mode and FSM state encodings for the memory fill engine.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mem_fill_pkg;

    localparam logic [1:0] MODE_FILL_CONST   = 2'b00;
    localparam logic [1:0] MODE_FILL_INCR    = 2'b01;
    localparam logic [1:0] MODE_VERIFY_CONST = 2'b10;
    localparam logic [1:0] MODE_VERIFY_INCR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit 1 of the mode selects verify; bit 0 selects the incrementing pattern.
    function automatic logic is_verify(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage : mem_fill_pkg

`default_nettype wire

// File: rtl/mem_fill_engine_if.sv
// ============================================================================
//  Module  : mem_fill_engine_if
//  Brief   : Command, status and memory-port bundle of the fill engine.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_fill_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) ();

    logic                  start;
    logic [1:0]            mode;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  length;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  busy;
    logic                  done;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  error;
    logic [LEN_WIDTH-1:0]  err_count;
    logic [ADDR_WIDTH-1:0] first_err_addr;

    // Engine side
    modport master (
        input  start, mode, base_addr, length, pattern, mem_rdata,
        output busy, done, mem_we, mem_addr, mem_wdata,
               error, err_count, first_err_addr
    );

    // Processor / memory side
    modport slave (
        output start, mode, base_addr, length, pattern, mem_rdata,
        input  busy, done, mem_we, mem_addr, mem_wdata,
               error, err_count, first_err_addr
    );

endinterface : mem_fill_engine_if

`default_nettype wire

// File: rtl/mem_fill_pattern.sv
// ============================================================================
//  Module  : mem_fill_pattern
//  Brief   : Combinational expected-word generator (constant or pattern + i).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_fill_pattern #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic [DATA_WIDTH-1:0] i_pattern,
    input  logic [LEN_WIDTH-1:0]  i_idx,
    input  logic                  i_incr,
    output logic [DATA_WIDTH-1:0] o_expected
);

    // The sum wraps modulo 2^DATA_WIDTH by construction.
    assign o_expected = i_incr ? (i_pattern + DATA_WIDTH'(i_idx)) : i_pattern;

endmodule : mem_fill_pattern

`default_nettype wire

// File: rtl/mem_fill_engine.sv
// ============================================================================
//  Module  : mem_fill_engine
//  Brief   : One-word-per-cycle memory fill / verify engine with error tally.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_fill_engine
    import mem_fill_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_fill_engine_if.master bus
);

    localparam int C_WORD_BYTES = DATA_WIDTH / 8;

    state_t                r_state;
    logic [1:0]            r_mode;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [DATA_WIDTH-1:0] r_pattern;
    logic [LEN_WIDTH-1:0]  r_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [LEN_WIDTH-1:0]  r_err_count;
    logic [ADDR_WIDTH-1:0] r_first_err;

    logic [DATA_WIDTH-1:0] w_expected;
    logic                  w_mismatch;
    logic                  w_last;

    mem_fill_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_pattern (
        .i_pattern  (r_pattern),
        .i_idx      (r_idx),
        .i_incr     (r_mode[0]),
        .o_expected (w_expected)
    );

    assign w_mismatch = (r_state == ST_RUN) && is_verify(r_mode) &&
                        (bus.mem_rdata != w_expected);
    assign w_last     = (r_idx == (r_len - LEN_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= '0;
            r_len       <= '0;
            r_pattern   <= '0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= '0;
            r_first_err <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mode      <= bus.mode;
                        r_len       <= bus.length;
                        r_pattern   <= bus.pattern;
                        r_addr      <= bus.base_addr;
                        r_idx       <= '0;
                        r_error     <= 1'b0;
                        r_err_count <= '0;
                        r_first_err <= '0;
                        if (bus.length != '0) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_we    <= ~is_verify(bus.mode);
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_mismatch) begin
                        if (r_err_count != '1) begin
                            r_err_count <= r_err_count + LEN_WIDTH'(1);
                        end
                        r_error <= 1'b1;
                        // err_count never returns to zero, so r_error marks "seen one".
                        if (!r_error) begin
                            r_first_err <= r_addr;
                        end
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx  <= r_idx + LEN_WIDTH'(1);
                        r_addr <= r_addr + ADDR_WIDTH'(C_WORD_BYTES);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gating with reset keeps the write strobe low during the reset cycle itself.
    assign bus.mem_we         = r_we & ~reset;
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wdata      = w_expected;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.error          = r_error;
    assign bus.err_count      = r_err_count;
    assign bus.first_err_addr = r_first_err;

endmodule : mem_fill_engine

`default_nettype wire

// File: tb/tb_mem_fill_engine.sv
// ============================================================================
//  Module  : tb_mem_fill_engine
//  Brief   : Self-checking bench for mem_fill_engine with a 128-word memory.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_fill_engine;
    import mem_fill_pkg::*;

    localparam logic [31:0] INIT = 32'h5A5A_5A5A;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] base;
        logic [15:0] len;
        logic [31:0] pat;
        logic        corrupt;
        logic [15:0] exp_err;
        logic [31:0] exp_first;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_fill_engine_if bus ();

    mem_fill_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem   [0:127];
    logic [31:0] model [0:127];
    logic        mem_clr;
    logic        poke_en;
    logic [6:0]  poke_idx;
    logic [31:0] poke_data;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 128; k++) mem[k] <= INIT;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
        end else if (poke_en) begin
            mem[poke_idx] <= poke_data;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_image(input string name);
        int bad = -1;
        for (int k = 0; k < 128; k++) begin
            if (bad < 0 && mem[k] !== model[k]) bad = k;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: word %0d got %0h expected %0h", name, bad, mem[bad], model[bad]);
        end
    endtask

    task automatic model_fill(input logic [1:0] mode, input logic [31:0] base,
                              input int n, input logic [31:0] pat);
        for (int k = 0; k < n; k++) begin
            model[(base >> 2) + k] = mode[0] ? pat + 32'(k) : pat;
        end
    endtask

    // Issues one command and follows it to done; lat counts cycles from start.
    task automatic run_cmd(input vec_t v, output int lat, output int busy_n, output int we_n);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.mode      = v.mode;
        bus.base_addr = v.base;
        bus.length    = v.len;
        bus.pattern   = v.pat;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat    = 1;
        busy_n = int'(bus.busy);
        we_n   = int'(bus.mem_we);
        while (!bus.done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            busy_n += int'(bus.busy);
            we_n   += int'(bus.mem_we);
        end
    endtask

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy_n, we_n, done_n;

        vecs[0] = '{MODE_FILL_CONST,   32'h00, 16'd16, 32'hFEFE_FEFE, 1'b0, 16'd0, 32'h00};
        vecs[1] = '{MODE_FILL_INCR,    32'h40, 16'd4,  32'hFFFF_FFFE, 1'b0, 16'd0, 32'h00};
        vecs[2] = '{MODE_VERIFY_CONST, 32'h00, 16'd16, 32'hFEFE_FEFE, 1'b1, 16'd1, 32'h20};
        vecs[3] = '{MODE_VERIFY_INCR,  32'h40, 16'd4,  32'hFFFF_FFFC, 1'b0, 16'd4, 32'h40};
        vecs[4] = '{MODE_FILL_CONST,   32'h80, 16'd0,  32'h1234_5678, 1'b0, 16'd0, 32'h00};
        vecs[5] = '{MODE_VERIFY_INCR,  32'h40, 16'd4,  32'hFFFF_FFFE, 1'b0, 16'd0, 32'h00};

        for (int k = 0; k < 128; k++) model[k] = INIT;
        bus.start = 1'b0; bus.mode = 2'b00; bus.base_addr = '0; bus.length = '0; bus.pattern = '0;
        poke_en = 1'b0; poke_idx = '0; poke_data = '0;
        reset = 1'b1; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",      64'(bus.busy), 64'(0));
        check("reset done",      64'(bus.done), 64'(0));
        check("reset mem_we",    64'(bus.mem_we), 64'(0));
        check("reset mem_addr",  64'(bus.mem_addr), 64'(0));
        check("reset mem_wdata", 64'(bus.mem_wdata), 64'(0));
        check("reset error",     64'(bus.error), 64'(0));
        check("reset err_count", 64'(bus.err_count), 64'(0));
        check("reset first_err", 64'(bus.first_err_addr), 64'(0));
        reset = 1'b0; mem_clr = 1'b0;

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].corrupt) begin
                // Byte 0x23 is the top byte of word 8 (little-endian).
                model[8] = {8'h00, model[8][23:0]};
                @(posedge clk); #1;
                poke_en = 1'b1; poke_idx = 7'd8; poke_data = model[8];
                @(posedge clk); #1;
                poke_en = 1'b0;
            end
            run_cmd(vecs[v], lat, busy_n, we_n);
            if (!vecs[v].mode[1]) model_fill(vecs[v].mode, vecs[v].base, int'(vecs[v].len), vecs[v].pat);
            check($sformatf("v%0d latency", v),   64'(lat),    64'(vecs[v].len) + 64'd1);
            check($sformatf("v%0d busy", v),      64'(busy_n), 64'(vecs[v].len));
            check($sformatf("v%0d we", v),        64'(we_n),   vecs[v].mode[1] ? 64'd0 : 64'(vecs[v].len));
            check($sformatf("v%0d err_count", v), 64'(bus.err_count), 64'(vecs[v].exp_err));
            check($sformatf("v%0d error", v),     64'(bus.error), 64'(vecs[v].exp_err != 0));
            check($sformatf("v%0d first_err", v), 64'(bus.first_err_addr), 64'(vecs[v].exp_first));
            check_image($sformatf("v%0d memory", v));
            if (v == 0) check("byte 64 untouched", 64'(mem[16]), 64'(INIT));
            if (v == 1) check("incr wrap word", 64'(mem[18]), 64'h0);
        end

        // Reset in the middle of a 16-word fill at 0x80.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = MODE_FILL_CONST; bus.base_addr = 32'h80;
        bus.length = 16'd16; bus.pattern = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst busy",     64'(bus.busy), 64'(0));
        check("midrst mem_we",   64'(bus.mem_we), 64'(0));
        check("midrst mem_addr", 64'(bus.mem_addr), 64'(0));
        check("midrst wdata",    64'(bus.mem_wdata), 64'(0));
        done_n = 0;
        repeat (20) begin
            @(posedge clk); #1;
            done_n += int'(bus.done) + int'(bus.mem_we);
        end
        check("midrst no done/we", 64'(done_n), 64'(0));
        model_fill(MODE_FILL_CONST, 32'h80, 5, 32'hCAFE_F00D);
        check_image("midrst memory");

        // start held high through an 8-word fill while operands change.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = MODE_FILL_CONST; bus.base_addr = 32'hC0;
        bus.length = 16'd8; bus.pattern = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        bus.mode = MODE_FILL_INCR; bus.base_addr = 32'h100;
        bus.length = 16'd4; bus.pattern = 32'h10;
        lat = 1; busy_n = int'(bus.busy);
        while (!bus.done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            busy_n += int'(bus.busy);
        end
        check("held latency", 64'(lat), 64'(9));
        check("held busy",    64'(busy_n), 64'(8));
        check("held B not yet written", 64'(mem[64]), 64'(INIT));
        @(posedge clk); #1;
        check("held start in DONE ignored", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
        check("held restart accepted", 64'(bus.busy), 64'(1));
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check("restart latency", 64'(lat), 64'(5));
        model_fill(MODE_FILL_CONST, 32'hC0, 8, 32'hA5A5_A5A5);
        model_fill(MODE_FILL_INCR, 32'h100, 4, 32'h10);
        check_image("held memory");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_fill_engine

`default_nettype wire
